// File: rtl/muldiv_iter_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes,
// FSM state encoding and small decode helpers.
package muldiv_iter_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } md_state_e;

    function automatic logic is_muldiv(md_op_e op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_signed_op(md_op_e op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

    function automatic logic is_div_op(md_op_e op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_iter_if.sv
// Request/result bundle between the E-stage and the multiply/divide unit.
interface muldiv_iter_if #(
    parameter int WIDTH = 32
);
    import muldiv_iter_pkg::*;

    logic             start;
    md_op_e           op;
    logic [WIDTH-1:0] operand1;
    logic [WIDTH-1:0] operand2;
    logic             cancel;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;

    modport master (
        output start, op, operand1, operand2, cancel,
        input  hi, lo, busy, done
    );

    modport slave (
        input  start, op, operand1, operand2, cancel,
        output hi, lo, busy, done
    );

endinterface

// File: rtl/muldiv_iter_step.sv
// One combinational iteration: shift-add for multiply, restoring
// trial-subtract for divide, chosen by is_div.
module muldiv_iter_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] upper,
    input  logic [WIDTH-1:0] lower,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] upper_next,
    output logic [WIDTH-1:0] lower_next
);

    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             fits;

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the block leaves a value unassigned and infers a latch.
    always_comb begin
        upper_next = upper;
        lower_next = lower;
        addend     = lower[0] ? operand : '0;
        sum        = {1'b0, upper} + {1'b0, addend};
        shifted    = {upper, lower[WIDTH-1]};
        trial      = shifted - {1'b0, operand};
        fits       = ~trial[WIDTH];
        if (is_div) begin
            // Partial remainder < divisor, so a borrow in bit WIDTH means "did not fit".
            upper_next = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
            lower_next = {lower[WIDTH-2:0], fits};
        end else begin
            upper_next = sum[WIDTH:1];
            lower_next = {sum[0], lower[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_iter.sv
// Iterative multiply/divide unit with architectural HI/LO, fixed latency of
// WIDTH+1 busy cycles per mul/div, cancel and defined divide-by-zero results.
module muldiv_iter
    import muldiv_iter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          reset,
    muldiv_iter_if.slave  md
);

    localparam int CW = $clog2(WIDTH) + 1;

    md_state_e        state, state_next;
    logic [CW-1:0]    count;
    logic             accept, commit, mt_hi, mt_lo;

    logic             is_div, neg_q, neg_r, div_zero;
    logic [WIDTH-1:0] op1_raw, operand_q;
    logic [WIDTH-1:0] upper, lower, upper_next, lower_next;
    logic [WIDTH-1:0] hi_q, lo_q, hi_res, lo_res;
    logic             done_q;

    logic             sign1, sign2;
    logic [WIDTH-1:0] mag1, mag2;
    logic [2*WIDTH-1:0] prod;

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        unique case (state)
            IDLE: if (md.start && !md.cancel && is_muldiv(md.op)) begin
                state_next = CALC;
                accept     = 1'b1;
            end
            CALC: if (md.cancel)                       state_next = IDLE;
                  else if (count == CW'(WIDTH - 1))    state_next = FIX;
            FIX:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign commit = (state == FIX) && !md.cancel;
    assign mt_hi  = (state == IDLE) && md.start && !md.cancel && (md.op == MD_MTHI);
    assign mt_lo  = (state == IDLE) && md.start && !md.cancel && (md.op == MD_MTLO);

    // The unsigned core only ever sees magnitudes; signs are reapplied in FIX.
    assign sign1 = is_signed_op(md.op) && md.operand1[WIDTH-1];
    assign sign2 = is_signed_op(md.op) && md.operand2[WIDTH-1];
    assign mag1  = sign1 ? -md.operand1 : md.operand1;
    assign mag2  = sign2 ? -md.operand2 : md.operand2;

    muldiv_iter_step #(.WIDTH(WIDTH)) u_step (
        .is_div     (is_div),
        .upper      (upper),
        .lower      (lower),
        .operand    (operand_q),
        .upper_next (upper_next),
        .lower_next (lower_next)
    );

    assign prod = {upper, lower};

    always_comb begin
        hi_res = upper;
        lo_res = lower;
        if (!is_div) begin
            {hi_res, lo_res} = neg_q ? -prod : prod;
        end else if (div_zero) begin
            hi_res = op1_raw;
            lo_res = '1;
        end else begin
            lo_res = neg_q ? -lower : lower;
            hi_res = neg_r ? -upper : upper;
        end
    end

    // NOTE: all state is updated with non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count     <= '0;
            is_div    <= 1'b0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            div_zero  <= 1'b0;
            op1_raw   <= '0;
            operand_q <= '0;
            upper     <= '0;
            lower     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= commit;
            unique case (state)
                IDLE: begin
                    count <= '0;
                    if (accept) begin
                        is_div    <= is_div_op(md.op);
                        neg_q     <= sign1 ^ sign2;
                        neg_r     <= sign1;
                        div_zero  <= is_div_op(md.op) && (md.operand2 == '0);
                        op1_raw   <= md.operand1;
                        operand_q <= mag2;
                        upper     <= '0;
                        lower     <= mag1;
                    end
                    if (mt_hi) hi_q <= md.operand1;
                    if (mt_lo) lo_q <= md.operand1;
                end
                CALC: begin
                    count <= count + 1'b1;
                    upper <= upper_next;
                    lower <= lower_next;
                end
                FIX: begin
                    count <= '0;
                    if (commit) begin
                        hi_q <= hi_res;
                        lo_q <= lo_res;
                    end
                end
                default: count <= '0;
            endcase
        end
    end

    assign md.hi   = hi_q;
    assign md.lo   = lo_q;
    assign md.busy = (state != IDLE);
    assign md.done = done_q;

endmodule
